isa_cycle_master: RTL and testbench
===================================

// Module: isa_cycle_master
// PURPOSE
// - ISA bus initiator: turns single CPU-side I/O/memory requests into 8-bit ISA cycles.
// - Drives the address, AEN, command strobes and write data that video adapters and other
//   responders decode; samples their read data, bus_dir and bus_rdy.
// - Sits between the CPU core/bus arbiter and every ISA-attached peripheral.
// PARAMETERS
// - SETUP_CYCLES    2    clocks address/AEN/write-data valid before the strobe asserts (>=1)
// - CMD_MIN_CYCLES  4    minimum strobe-low clocks, whatever bus_rdy does (>=1)
// - HOLD_CYCLES     1    clocks address/data held after the strobe deasserts (>=1)
// - RDY_TIMEOUT     255  max extra wait clocks with bus_rdy low before an abort (8-bit counter)
// PORTS
// - clk          in   1   system clock
// - reset        in   1   synchronous, active-high
// - req_valid    in   1   request present
// - req_ready    out  1   request accepted on the cycle where valid&ready
// - req_op       in   2   0=IOR 1=IOW 2=MEMR 3=MEMW
// - req_addr     in   20  byte address (I/O uses [15:0], [19:16] forced 0)
// - req_wdata    in   8   write data
// - rsp_valid    out  1   response available, held until rsp_ready
// - rsp_ready    in   1   response consumed
// - rsp_rdata    out  8   read data (0x00 for writes)
// - rsp_err      out  1   cycle aborted by bus_rdy timeout
// - bus_a        out  20  ISA address
// - bus_aen      out  1   1 = no CPU cycle (idle); 0 during SETUP..HOLD
// - bus_ior_l    out  1   I/O read strobe, active low
// - bus_iow_l    out  1   I/O write strobe, active low
// - bus_memr_l   out  1   memory read strobe, active low
// - bus_memw_l   out  1   memory write strobe, active low
// - bus_d_out    out  8   write data to the bus
// - bus_d_oe     out  1   initiator drives the data bus
// - bus_d_in     in   8   read data from the responder
// - bus_dir      in   1   responder drives the data bus (read)
// - bus_rdy      in   1   responder ready; 0 inserts wait states
// BEHAVIOUR
// - Reset values: all *_l=1, bus_aen=1, bus_a=0, bus_d_out=0, bus_d_oe=0, req_ready=0,
//   rsp_valid=0, rsp_rdata=0, rsp_err=0. All outputs are registered.
// - FSM IDLE -> SETUP -> CMD -> HOLD -> RESP -> IDLE.
// - IDLE: req_ready=1.
//   - On valid&ready: latch op/addr/wdata, drive bus_a and bus_aen=0.
//   - Writes: bus_d_oe=1 and bus_d_out=wdata from SETUP through HOLD.
// - SETUP: SETUP_CYCLES clocks, then the strobe selected by op asserts at the CMD entry edge.
//   Exactly one strobe is ever low.
// - CMD: the strobe stays low for at least CMD_MIN_CYCLES.
//   - The strobe deasserts on the first clock >= CMD_MIN_CYCLES where bus_rdy=1 (sampled).
//   - Each extra low clock increments a wait counter.
//   - Counter reaching RDY_TIMEOUT: deassert, rsp_err=1.
// - Read capture: on the clock the strobe deasserts, take rdata=bus_d_in if bus_dir=1,
//   else 0xFF (floating bus). On timeout rdata=0xFF.
// - HOLD: HOLD_CYCLES clocks with address/data unchanged; then bus_aen=1 and bus_d_oe=0.
// - RESP: rsp_valid=1 until rsp_ready. Same-cycle rsp_ready goes to IDLE next clock.
//   req_ready stays 0 until then: one outstanding cycle.
// - Minimum latency, accept to rsp_valid: SETUP_CYCLES + CMD_MIN_CYCLES + HOLD_CYCLES + 1.
// - req_valid while busy is ignored; no queueing.
// - Reset mid-cycle: strobes high and aen=1 at the next edge, no response issued,
//   the latched request is dropped.
// - bus_rdy is ignored outside CMD; bus_dir is ignored for writes.
// STRUCTURE
// - isa_defs.vh: OP_IOR/OP_IOW/OP_MEMR/OP_MEMW and FSM state localparams, shared with the
//   bus arbiter and the bench.
// - One sub-module: isa_phase_counter (load value, decrement, zero flag), reused for the
//   SETUP/CMD/HOLD counts; the wait counter is inline.
// TESTING
// - IOW 0x3D8 data 0x29, bus_rdy=1 -> iow_l low exactly 4 clks, aen=0 for 2+4+1 clks,
//   d_oe=1 throughout, rsp_err=0.
// - IOR 0x3DA, responder bus_dir=1 d_in=0xF9 -> rsp_rdata=0xF9, rsp_valid 8 clks after accept.
// - MEMR 0xB8000, bus_rdy low for 10 clks after CMD min -> strobe low 14 clks, rdata correct.
// - MEMR with bus_dir=0 -> rdata=0xFF, err=0.
// - bus_rdy stuck low, RDY_TIMEOUT=255 -> abort after 4+255 strobe clks, rsp_err=1, rdata=0xFF.
// - reset during CMD of IOW -> next clk all strobes 1, aen=1, d_oe=0, no rsp_valid.
// - rsp_ready held low 5 clks -> rsp_valid and req_ready=0 stable; a new req_valid is
//   not accepted until after the handshake.

Source files
------------

// File: rtl/isa_cycle_master_pkg.sv
// Shared definitions for the ISA cycle initiator: op codes, FSM state encodings
// and small decode helpers used by the RTL and the bench.
package isa_cycle_master_pkg;

  localparam logic [1:0] OP_IOR  = 2'd0;
  localparam logic [1:0] OP_IOW  = 2'd1;
  localparam logic [1:0] OP_MEMR = 2'd2;
  localparam logic [1:0] OP_MEMW = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  function automatic logic op_is_write(input logic [1:0] op);
    return op[0];
  endfunction

  // I/O cycles only decode 16 address bits, so the top nibble is forced low.
  function automatic logic [19:0] bus_addr(input logic [1:0] op, input logic [19:0] addr);
    return op[1] ? addr : {4'h0, addr[15:0]};
  endfunction

  // Active-low strobe vector ordered {memw, memr, iow, ior}.
  function automatic logic [3:0] strobe_pattern(input logic [1:0] op);
    logic [3:0] pat;
    case (op)
      OP_IOR:  pat = 4'b1110;
      OP_IOW:  pat = 4'b1101;
      OP_MEMR: pat = 4'b1011;
      OP_MEMW: pat = 4'b0111;
      default: pat = 4'b1111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/isa_cycle_master_if.sv
// Request/response handshake and ISA bus signals between the initiator and its
// CPU-side requester / ISA responders.
interface isa_cycle_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [19:0] bus_a;
  logic        bus_aen;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        bus_dir;
  logic        bus_rdy;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_d_in, bus_dir, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_a, bus_aen,
           bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_d_out, bus_d_oe
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_d_in, bus_dir, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_a, bus_aen,
           bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_d_out, bus_d_oe
  );
endinterface

// File: rtl/isa_cycle_master_phase_counter.sv
// Loadable down-counter with a zero flag; times the SETUP, CMD-minimum and HOLD
// phases of an ISA cycle.
module isa_cycle_master_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/isa_cycle_master.sv
// ISA bus initiator: runs one 8-bit I/O or memory cycle per accepted request
// with programmable setup, minimum command width, hold and bus_rdy timeout.
module isa_cycle_master
  import isa_cycle_master_pkg::*;
#(
  parameter int         SETUP_CYCLES   = 2,
  parameter int         CMD_MIN_CYCLES = 4,
  parameter int         HOLD_CYCLES    = 1,
  parameter logic [7:0] RDY_TIMEOUT    = 8'd255
) (
  input logic                 clk,
  input logic                 reset,
  isa_cycle_master_if.master  isa
);

  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] CMD_LOAD   = 8'(CMD_MIN_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q;
  logic [7:0]  wait_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [7:0]  rsp_rdata_q;
  logic [19:0] bus_a_q;
  logic        bus_aen_q, bus_d_oe_q;
  logic [7:0]  bus_d_out_q;
  logic [3:0]  strobe_l_q;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic [7:0]  cnt_val;
  logic        accept, cmd_done, timeout;

  isa_cycle_master_phase_counter #(.WIDTH(8)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Once the minimum strobe width has elapsed, CMD ends on bus_rdy or on the wait limit.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    accept   = 1'b0;
    cmd_done = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_ready_q && isa.req_valid) begin
          accept   = 1'b1;
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_CMD;
          cnt_load = 1'b1;
          cnt_val  = CMD_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CMD: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (isa.bus_rdy) begin
          cmd_done = 1'b1;
        end else if (wait_q == RDY_TIMEOUT) begin
          cmd_done = 1'b1;
          timeout  = 1'b1;
        end
        if (cmd_done) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && isa.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_IOR;
      wait_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_a_q     <= '0;
      bus_aen_q   <= 1'b1;
      bus_d_out_q <= '0;
      bus_d_oe_q  <= 1'b0;
      strobe_l_q  <= 4'hF;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q        <= isa.req_op;
            bus_a_q     <= bus_addr(isa.req_op, isa.req_addr);
            bus_aen_q   <= 1'b0;
            bus_d_oe_q  <= op_is_write(isa.req_op);
            bus_d_out_q <= isa.req_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            strobe_l_q <= strobe_pattern(op_q);
          end
        end
        ST_CMD: begin
          if (cmd_done) begin
            strobe_l_q <= 4'hF;
            rsp_err_q  <= timeout;
            // A responder not driving the bus leaves it floating high.
            if (timeout || (!op_is_write(op_q) && !isa.bus_dir)) begin
              rsp_rdata_q <= 8'hFF;
            end else if (!op_is_write(op_q)) begin
              rsp_rdata_q <= isa.bus_d_in;
            end
          end else if (cnt_zero) begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            bus_aen_q  <= 1'b1;
            bus_d_oe_q <= 1'b0;
          end
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (isa.rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign isa.req_ready  = req_ready_q;
  assign isa.rsp_valid  = rsp_valid_q;
  assign isa.rsp_rdata  = rsp_rdata_q;
  assign isa.rsp_err    = rsp_err_q;
  assign isa.bus_a      = bus_a_q;
  assign isa.bus_aen    = bus_aen_q;
  assign isa.bus_ior_l  = strobe_l_q[0];
  assign isa.bus_iow_l  = strobe_l_q[1];
  assign isa.bus_memr_l = strobe_l_q[2];
  assign isa.bus_memw_l = strobe_l_q[3];
  assign isa.bus_d_out  = bus_d_out_q;
  assign isa.bus_d_oe   = bus_d_oe_q;

endmodule

// File: tb/tb_isa_cycle_master.sv
// Directed self-checking bench for isa_cycle_master: times strobes, AEN and
// response latency against hand-computed values for each ISA cycle type.
module tb_isa_cycle_master;
  import isa_cycle_master_pkg::*;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  isa_cycle_master_if isa ();

  isa_cycle_master dut (
    .clk   (clk),
    .reset (reset),
    .isa   (isa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for the accept edge; returns at the sample just after it.
  task automatic acceptRequest(input logic [1:0] op, input logic [19:0] addr,
                               input logic [7:0] wdata, output bit ok);
    ok = 1'b0;
    isa.req_op    = op;
    isa.req_addr  = addr;
    isa.req_wdata = wdata;
    isa.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (isa.req_ready) begin
        ok = 1'b1;
        nextCycle();
        break;
      end
      nextCycle();
    end
    isa.req_valid = 1'b0;
  endtask

  // One full cycle; waitClks = sampled bus_rdy-low clocks after the command minimum.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [19:0] addr,
                               input logic [7:0] wdata, input logic dir, input logic [7:0] din,
                               input int waitClks, input int holdRsp, input int expStrobe,
                               input logic [7:0] expRdata, input logic expErr,
                               input logic [19:0] expA);
    bit   ok;
    int   strobeLow, otherLow, aenLow, doeBad, latency;
    logic [3:0] strobes;
    logic [19:0] seenA;
    logic [7:0]  seenDout;
    isa.bus_dir  = dir;
    isa.bus_d_in = din;
    isa.bus_rdy  = 1'b0;
    acceptRequest(op, addr, wdata, ok);
    if (!ok) begin
      checkOutput({tag, " accept"}, 32'd0, 32'd1);
      return;
    end
    strobeLow = 0; otherLow = 0; aenLow = 0; doeBad = 0; latency = -1;
    seenA = isa.bus_a;
    seenDout = isa.bus_d_out;
    for (int k = 0; k < 400; k++) begin
      if (isa.rsp_valid) begin
        latency = k;
        break;
      end
      strobes = {isa.bus_memw_l, isa.bus_memr_l, isa.bus_iow_l, isa.bus_ior_l};
      if (!strobes[op]) strobeLow++;
      if ((strobes | (4'b1 << op)) != 4'hF) otherLow++;
      if (!isa.bus_aen) begin
        aenLow++;
        if (isa.bus_d_oe !== op[0]) doeBad++;
      end
      isa.bus_rdy = (strobeLow >= 4 + waitClks);
      nextCycle();
    end
    checkOutput({tag, " strobe_clks"}, strobeLow, expStrobe);
    checkOutput({tag, " other_strobes"}, otherLow, 0);
    checkOutput({tag, " aen_clks"}, aenLow, 2 + expStrobe + 1);
    checkOutput({tag, " d_oe"}, doeBad, 0);
    checkOutput({tag, " latency"}, latency, 2 + expStrobe + 1 + 1);
    checkOutput({tag, " bus_a"}, seenA, expA);
    if (op[0]) checkOutput({tag, " d_out"}, seenDout, wdata);
    checkOutput({tag, " rdata"}, isa.rsp_rdata, expRdata);
    checkOutput({tag, " err"}, isa.rsp_err, expErr);
    checkOutput({tag, " d_oe_after"}, isa.bus_d_oe, 0);
    isa.bus_rdy = 1'b1;
    for (int h = 0; h < holdRsp; h++) begin
      isa.req_valid = 1'b1;
      checkOutput({tag, " hold_rsp_valid"}, isa.rsp_valid, 1);
      checkOutput({tag, " hold_req_ready"}, isa.req_ready, 0);
      checkOutput({tag, " hold_aen"}, isa.bus_aen, 1);
      nextCycle();
    end
    isa.req_valid = 1'b0;
    isa.rsp_ready = 1'b1;
    nextCycle();
    isa.rsp_ready = 1'b0;
    checkOutput({tag, " rsp_cleared"}, isa.rsp_valid, 0);
    checkOutput({tag, " req_ready_back"}, isa.req_ready, 1);
    checkOutput({tag, " aen_idle"}, isa.bus_aen, 1);
  endtask

  initial begin
    bit ok;
    int n;
    testsRun = 0;
    testsFailed = 0;
    isa.req_valid = 1'b0; isa.req_op = OP_IOR; isa.req_addr = '0; isa.req_wdata = '0;
    isa.rsp_ready = 1'b0; isa.bus_d_in = '0; isa.bus_dir = 1'b0; isa.bus_rdy = 1'b1;
    reset = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("reset strobes", {isa.bus_memw_l, isa.bus_memr_l, isa.bus_iow_l, isa.bus_ior_l}, 4'hF);
    checkOutput("reset aen", isa.bus_aen, 1);
    checkOutput("reset bus_a", isa.bus_a, 0);
    checkOutput("reset d_out_oe", {isa.bus_d_out, isa.bus_d_oe}, 0);
    checkOutput("reset req_ready", isa.req_ready, 0);
    checkOutput("reset rsp", {isa.rsp_valid, isa.rsp_err, isa.rsp_rdata}, 0);
    reset = 1'b0;
    nextCycle();

    applyStimulus("iow", OP_IOW, 20'h003D8, 8'h29, 1'b1, 8'h77, 0, 5, 4, 8'h00, 1'b0, 20'h003D8);
    applyStimulus("ior", OP_IOR, 20'h003DA, 8'h00, 1'b1, 8'hF9, 0, 0, 4, 8'hF9, 1'b0, 20'h003DA);
    applyStimulus("ior_hiaddr", OP_IOR, 20'hA1234, 8'h00, 1'b1, 8'h5C, 0, 1, 4, 8'h5C, 1'b0, 20'h01234);
    applyStimulus("memr_wait", OP_MEMR, 20'hB8000, 8'h00, 1'b1, 8'h41, 10, 0, 14, 8'h41, 1'b0, 20'hB8000);
    applyStimulus("memr_float", OP_MEMR, 20'hB8001, 8'h00, 1'b0, 8'h12, 0, 0, 4, 8'hFF, 1'b0, 20'hB8001);
    applyStimulus("memw", OP_MEMW, 20'hA0010, 8'hC3, 1'b1, 8'h00, 2, 0, 6, 8'h00, 1'b0, 20'hA0010);
    applyStimulus("memr_timeout", OP_MEMR, 20'hC0000, 8'h00, 1'b1, 8'h33, 1000, 0, 259, 8'hFF, 1'b1, 20'hC0000);

    // Reset in the middle of an I/O write command phase.
    isa.bus_rdy = 1'b0;
    acceptRequest(OP_IOW, 20'h00300, 8'h5A, ok);
    checkOutput("rst_mid accept", ok, 1);
    n = 0;
    while (isa.bus_iow_l && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("rst_mid iow_low", isa.bus_iow_l, 0);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("rst_mid strobes", {isa.bus_memw_l, isa.bus_memr_l, isa.bus_iow_l, isa.bus_ior_l}, 4'hF);
    checkOutput("rst_mid aen", isa.bus_aen, 1);
    checkOutput("rst_mid d_oe", isa.bus_d_oe, 0);
    checkOutput("rst_mid rsp_valid", isa.rsp_valid, 0);
    isa.bus_rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (isa.rsp_valid) n++;
    end
    checkOutput("rst_mid no_rsp", n, 0);
    checkOutput("rst_mid req_ready", isa.req_ready, 1);

    applyStimulus("after_rst", OP_IOR, 20'h00060, 8'h00, 1'b1, 8'h1C, 0, 0, 4, 8'h1C, 1'b0, 20'h00060);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
